aud_recorder: RTL and testbench
===============================

// Module: aud_recorder
// PURPOSE
//   I2S receiver for the codec ADC path: deserialises the MSB-first serial ADC stream
//   (i_adcdat) into DATA_W-bit parallel samples of one selected channel.
//   Sits between the codec pins (BCLK/ADCLRCK/ADCDAT, codec is I2S master) and the
//   recorder/SRAM-write logic, which consumes o_data on the o_valid strobe.
//   Counterpart of the DAC player on the same I2S bus.
// PARAMETERS
//   DATA_W   16  sample width in bits (valid range 2..31)
//   CHANNEL  0   0: capture left word (ADCLRCK low half); 1: capture right word (ADCLRCK high half)
// PORTS
//   i_bclk      in   1       bit clock from codec; all logic on posedge
//   i_rst_n     in   1       asynchronous, active-low reset
//   i_en        in   1       record enable, level, sampled on posedge i_bclk
//   i_adclrck   in   1       ADC L/R clock from codec (0 = left, 1 = right)
//   i_adcdat    in   1       serial ADC data, MSB first, codec drives it on negedge BCLK
//   o_data      out  DATA_W  last completed sample, held until the next one completes
//   o_valid     out  1       one-cycle strobe: o_data updated this cycle
//   o_busy      out  1       1 while in S_RECV (word capture in progress)
// BEHAVIOUR
// - Reset (async assert, sync release): state=S_IDLE, o_data=0, o_valid=0, o_busy=0,
//   shift register=0, bit counter=0, lrck_r=0. Reset mid-word discards the partial word.
// - lrck_r <= i_adclrck on every posedge in every state.
// - Start edge (evaluated at a posedge):
//   CHANNEL=0: lrck_r==1 && i_adclrck==0.  CHANNEL=1: lrck_r==0 && i_adclrck==1.
//   Stop edge is the opposite transition.
// - FSM (posedge i_bclk):
//   S_IDLE  : o_busy=0. If i_en==1 -> S_WAIT.
//   S_WAIT  : If start edge at posedge k -> S_RECV, cnt<=0.
//             Posedge k is the I2S 1-bit delay slot; its data is ignored.
//   S_RECV  : At posedges k+1..k+DATA_W: shreg <= {shreg[DATA_W-2:0], i_adcdat}, cnt<=cnt+1.
//             At posedge k+DATA_W (cnt==DATA_W-1):
//               o_data <= {shreg[DATA_W-2:0], i_adcdat}; o_valid <= 1; -> S_WAIT.
//             Bits after the LSB in the same half-frame are ignored.
// - Latency: o_valid is high for exactly the one cycle following posedge k+DATA_W.
//   It is cleared at the next posedge. Max one sample per LRCK frame.
// - i_en==0 sampled in any state -> S_IDLE next posedge.
//   Partial word discarded (shreg, cnt cleared), no o_valid, o_data holds its last value.
//   i_en rising while LRCK is mid-half-frame: no capture until the next start edge
//   (never a partial/misaligned word).
// - Stop edge seen in S_RECV before cnt reaches DATA_W-1 (half-frame shorter than DATA_W+1 BCLKs):
//   abort, no o_valid, -> S_WAIT, shreg/cnt cleared.
//   A start edge at the same posedge as a completing LSB cannot occur in valid framing;
//   the LSB completion takes priority.
// - Start edge while in S_IDLE is ignored (edge only acted upon in S_WAIT).
// - Counter width = $clog2(DATA_W); no wrap: it is reset on every S_RECV entry.
// - o_busy = (state == S_RECV), registered-state decode, no combinational input paths to outputs.
// TESTING
// 1. CHANNEL=0, i_en=1, 32 BCLK/half-frame, left word 16'hA5C3, right word 16'h1234:
//    -> o_data=16'hA5C3, o_valid high 1 cycle after 17th posedge past LRCK fall;
//       right word never appears.
// 2. CHANNEL=1, same stream -> o_data=16'h1234, one strobe per frame; 4 frames -> exactly 4 strobes.
// 3. i_en dropped after 8 bits of word 16'hFFFF (prior o_data=16'hA5C3):
//    -> no o_valid, o_data stays 16'hA5C3, state S_IDLE.
//    Re-enable mid-frame -> first capture on the next full word.
// 4. Short framing: 10 BCLK/half-frame, DATA_W=16 -> stop edge aborts every word; o_valid never asserts.
// 5. i_rst_n pulsed low asynchronously (between BCLK edges) during bit 5 of a word:
//    -> o_data=0, o_valid=0, o_busy=0 immediately.
//    After release, the next full word 16'h8001 is captured correctly.
// 6. Boundary patterns 16'h0000, 16'hFFFF, 16'h8000, 16'h0001 back-to-back
//    -> each reproduced exactly (checks MSB-first order and 1-bit delay slot skip).

Source files
------------

// File: rtl/aud_recorder.sv
// -----------------------------------------------------------------------------
// aud_recorder
//   I2S receiver for the codec ADC path. It deserialises the MSB-first serial
//   ADC stream into DATA_W-bit parallel samples of one selected channel. The
//   recorder/SRAM-write logic consumes o_data on the o_valid strobe.
//
//   Parameters
//     DATA_W   sample width in bits (2..31)
//     CHANNEL  0: capture the left word (ADCLRCK low half)
//              1: capture the right word (ADCLRCK high half)
//
//   Ports
//     i_bclk     bit clock from the codec; all logic runs on its posedge
//     i_rst_n    asynchronous, active-low reset
//     i_en       record enable (level)
//     i_adclrck  ADC L/R clock from the codec (0 = left, 1 = right)
//     i_adcdat   serial ADC data, MSB first, launched on negedge BCLK
//     o_data     last completed sample, held until the next one completes
//     o_valid    one-cycle strobe, o_data updated this cycle
//     o_busy     high while a word capture is in progress
// -----------------------------------------------------------------------------
module aud_recorder #(
    parameter int DATA_W  = 16,
    parameter int CHANNEL = 0
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                lrck_r;

    logic                start_s;
    logic                stop_s;
    logic [DATA_W-1:0]   shifted_s;

    // Decode LRCK transitions for the selected channel and form the next shift value.
    always_comb begin
        start_s   = 1'b0;
        stop_s    = 1'b0;
        shifted_s = {shreg_r[DATA_W-2:0], i_adcdat};
        if (CHANNEL == 0) begin
            // Left word starts on the falling LRCK edge.
            start_s = lrck_r & ~i_adclrck;
            stop_s  = ~lrck_r & i_adclrck;
        end else begin
            // Right word starts on the rising LRCK edge.
            start_s = ~lrck_r & i_adclrck;
            stop_s  = lrck_r & ~i_adclrck;
        end
    end

    // Capture FSM: waits for the channel's start edge, skips the 1-bit delay
    // slot, shifts DATA_W bits and publishes the word with a one-cycle strobe.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
            shreg_r <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            lrck_r  <= 1'b0;
            o_data  <= {DATA_W{1'b0}};
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            lrck_r  <= i_adclrck;
            o_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    shreg_r <= {DATA_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    o_busy  <= 1'b0;
                    // A start edge seen here is deliberately ignored; the
                    // first capture waits for a fresh edge observed in S_WAIT.
                    if (i_en) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    shreg_r <= {DATA_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    if (!i_en) begin
                        state_r <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (start_s) begin
                        // This posedge is the I2S delay slot; its data is not used.
                        state_r <= S_RECV;
                        o_busy  <= 1'b1;
                    end else begin
                        state_r <= S_WAIT;
                        o_busy  <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (!i_en) begin
                        // Disable discards the partial word; o_data keeps its value.
                        state_r <= S_IDLE;
                        shreg_r <= {DATA_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        o_busy  <= 1'b0;
                    end else if (cnt_r == LAST_CNT) begin
                        // LSB completion wins over any simultaneous LRCK edge.
                        o_data  <= shifted_s;
                        o_valid <= 1'b1;
                        state_r <= S_WAIT;
                        shreg_r <= {DATA_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        o_busy  <= 1'b0;
                    end else if (stop_s) begin
                        // Half-frame too short for a full word: drop it.
                        state_r <= S_WAIT;
                        shreg_r <= {DATA_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        o_busy  <= 1'b0;
                    end else begin
                        shreg_r <= shifted_s;
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= S_RECV;
                        o_busy  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    shreg_r <= {DATA_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aud_recorder.sv
// -----------------------------------------------------------------------------
// tb_aud_recorder
//   Directed bench for aud_recorder. Two instances share one I2S stream: u_l
//   captures the left word (CHANNEL=0), u_r the right word (CHANNEL=1).
//   A table of whole frames drives the main function; hand-written sequences
//   cover strobe latency, enable drop / re-enable and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_aud_recorder;

    logic        i_bclk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_adclrck;
    logic        i_adcdat;
    logic [15:0] data_l;
    logic        valid_l;
    logic        busy_l;
    logic [15:0] data_r;
    logic        valid_r;
    logic        busy_r;

    int checks;
    int errors;
    int strobes_l;
    int strobes_r;

    aud_recorder #(.DATA_W(16), .CHANNEL(0)) u_l (
        .i_bclk    (i_bclk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_adclrck (i_adclrck),
        .i_adcdat  (i_adcdat),
        .o_data    (data_l),
        .o_valid   (valid_l),
        .o_busy    (busy_l)
    );

    aud_recorder #(.DATA_W(16), .CHANNEL(1)) u_r (
        .i_bclk    (i_bclk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_adclrck (i_adclrck),
        .i_adcdat  (i_adcdat),
        .o_data    (data_r),
        .o_valid   (valid_r),
        .o_busy    (busy_r)
    );

    initial i_bclk = 1'b0;
    always #5 i_bclk = ~i_bclk;

    // Count strobes and latch strobed data, sampled away from the active edge.
    always @(negedge i_bclk) begin
        if (valid_l === 1'b1) strobes_l <= strobes_l + 1;
        if (valid_r === 1'b1) strobes_r <= strobes_r + 1;
    end

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        int          len;
        logic        en;
        logic [15:0] exp_dl;
        int          exp_sl;
        logic [15:0] exp_dr;
        int          exp_sr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive positions j0..j1 of a half-frame: position 0 is the delay slot,
    // positions 1..16 carry the word MSB first, later positions carry 0.
    task automatic drive_bits(input logic lr, input logic [15:0] w, input int j0, input int j1);
        int idx;
        for (int j = j0; j <= j1; j++) begin
            @(negedge i_bclk);
            i_adclrck = lr;
            if (j >= 1 && j <= 16) begin
                idx = 16 - j;
                i_adcdat = w[idx];
            end else begin
                i_adcdat = 1'b0;
            end
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int len);
        drive_bits(1'b0, l, 0, len - 1);
        drive_bits(1'b1, r, 0, len - 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        strobes_l = 0;
        strobes_r = 0;

        //             left      right     len en  exp_dl    sl exp_dr    sr
        vecs[0] = '{16'hA5C3, 16'h1234, 32, 1'b1, 16'hA5C3, 1, 16'h1234, 1};
        vecs[1] = '{16'h0000, 16'hFFFF, 32, 1'b1, 16'h0000, 1, 16'hFFFF, 1};
        vecs[2] = '{16'hFFFF, 16'h8000, 32, 1'b1, 16'hFFFF, 1, 16'h8000, 1};
        vecs[3] = '{16'h8000, 16'h0001, 32, 1'b1, 16'h8000, 1, 16'h0001, 1};
        vecs[4] = '{16'h0001, 16'h0000, 32, 1'b1, 16'h0001, 1, 16'h0000, 1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 10, 1'b1, 16'h0001, 0, 16'h0000, 0};
        vecs[6] = '{16'h1234, 16'h5678, 10, 1'b1, 16'h0001, 0, 16'h0000, 0};
        vecs[7] = '{16'hA5C3, 16'h1234, 32, 1'b0, 16'h0001, 0, 16'h0000, 0};
        // Enabled on the same posedge as the left start edge: edge is seen in
        // S_IDLE and ignored, so only the right word is captured.
        vecs[8] = '{16'h1111, 16'h2222, 32, 1'b1, 16'h0001, 0, 16'h2222, 1};
        vecs[9] = '{16'hA5C3, 16'h4321, 32, 1'b1, 16'hA5C3, 1, 16'h4321, 1};

        i_rst_n   = 1'b0;
        i_en      = 1'b0;
        i_adclrck = 1'b1;
        i_adcdat  = 1'b0;
        #12;
        chk("reset data_l",  {16'h0000, data_l},  32'h0000_0000);
        chk("reset valid_l", {31'd0, valid_l},    32'd0);
        chk("reset busy_l",  {31'd0, busy_l},     32'd0);
        chk("reset data_r",  {16'h0000, data_r},  32'h0000_0000);
        chk("reset valid_r", {31'd0, valid_r},    32'd0);
        chk("reset busy_r",  {31'd0, busy_r},     32'd0);

        @(negedge i_bclk);
        i_rst_n = 1'b1;
        i_en    = 1'b1;
        repeat (3) @(negedge i_bclk);

        // Strobe latency: high only after the 17th posedge past the LRCK fall.
        drive_bits(1'b0, 16'hA5C3, 0, 16);
        chk("lat valid before", {31'd0, valid_l}, 32'd0);
        drive_bits(1'b0, 16'hA5C3, 17, 17);
        chk("lat valid at",     {31'd0, valid_l}, 32'd1);
        chk("lat data",         {16'h0000, data_l}, 32'h0000_A5C3);
        drive_bits(1'b0, 16'hA5C3, 18, 18);
        chk("lat valid after",  {31'd0, valid_l}, 32'd0);
        drive_bits(1'b0, 16'hA5C3, 19, 31);
        drive_bits(1'b1, 16'h1234, 0, 31);
        chk("lat right data",   {16'h0000, data_r}, 32'h0000_1234);

        // Table of whole frames.
        for (int v = 0; v < 10; v++) begin
            strobes_l = 0;
            strobes_r = 0;
            @(negedge i_bclk);
            i_en      = vecs[v].en;
            i_adclrck = 1'b0;
            i_adcdat  = 1'b0;
            drive_bits(1'b0, vecs[v].left, 1, vecs[v].len - 1);
            drive_bits(1'b1, vecs[v].right, 0, vecs[v].len - 1);
            chk($sformatf("vec%0d strobes_l", v), strobes_l, vecs[v].exp_sl);
            chk($sformatf("vec%0d data_l", v), {16'h0000, data_l}, {16'h0000, vecs[v].exp_dl});
            chk($sformatf("vec%0d strobes_r", v), strobes_r, vecs[v].exp_sr);
            chk($sformatf("vec%0d data_r", v), {16'h0000, data_r}, {16'h0000, vecs[v].exp_dr});
        end

        // Enable dropped after 8 bits of 16'hFFFF.
        strobes_l = 0;
        drive_bits(1'b0, 16'hFFFF, 0, 9);
        chk("drop busy before", {31'd0, busy_l}, 32'd1);
        i_en = 1'b0;
        drive_bits(1'b0, 16'hFFFF, 10, 10);
        chk("drop busy after",  {31'd0, busy_l}, 32'd0);
        drive_bits(1'b0, 16'hFFFF, 11, 31);
        drive_bits(1'b1, 16'hFFFF, 0, 31);
        chk("drop strobes", strobes_l, 32'd0);
        chk("drop data",    {16'h0000, data_l}, 32'h0000_A5C3);

        // Re-enable mid left half: that word must not be captured.
        strobes_l = 0;
        strobes_r = 0;
        drive_bits(1'b0, 16'h5A5A, 0, 11);
        i_en = 1'b1;
        drive_bits(1'b0, 16'h5A5A, 12, 31);
        drive_bits(1'b1, 16'h1234, 0, 31);
        chk("reen strobes_l", strobes_l, 32'd0);
        chk("reen data_l",    {16'h0000, data_l}, 32'h0000_A5C3);
        chk("reen strobes_r", strobes_r, 32'd1);
        chk("reen data_r",    {16'h0000, data_r}, 32'h0000_1234);
        strobes_l = 0;
        frame(16'h3C3C, 16'h0000, 32);
        chk("reen next strobes", strobes_l, 32'd1);
        chk("reen next data",    {16'h0000, data_l}, 32'h0000_3C3C);

        // Asynchronous reset pulse during bit 5 of a word.
        drive_bits(1'b0, 16'hFFFF, 0, 5);
        chk("rst busy before", {31'd0, busy_l}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst data_l",  {16'h0000, data_l}, 32'h0000_0000);
        chk("rst valid_l", {31'd0, valid_l},   32'd0);
        chk("rst busy_l",  {31'd0, busy_l},    32'd0);
        #1;
        i_rst_n = 1'b1;
        drive_bits(1'b0, 16'hFFFF, 6, 31);
        drive_bits(1'b1, 16'h0000, 0, 31);
        strobes_l = 0;
        frame(16'h8001, 16'h0000, 32);
        chk("post rst strobes", strobes_l, 32'd1);
        chk("post rst data",    {16'h0000, data_l}, 32'h0000_8001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
